// File: rtl/bp_fe_bht_upd_sched_pkg.sv
// Shared types for the BHT update scheduler: FSM state and queued update entry.
// Entry idx is held at a fixed maximum width; modules narrow it to bht_idx_width_p at their ports.
package bp_fe_bht_upd_sched_pkg;

  localparam int unsigned bht_idx_width_max_gp = 16;

  typedef enum logic {
    e_normal,
    e_force
  } bht_upd_state_e;

  typedef struct packed {
    logic [bht_idx_width_max_gp-1:0] idx;
    logic                            correct;
  } bht_upd_entry_s;

endpackage

// File: rtl/bp_fe_bht_upd_fifo.sv
// In-order update queue: valid/ready enqueue, yumi dequeue, registered occupancy.
module bp_fe_bht_upd_fifo
  import bp_fe_bht_upd_sched_pkg::*;
#(
  parameter int unsigned els_p = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       v_i,
  input  bht_upd_entry_s             data_i,
  output logic                       ready_o,
  output logic                       v_o,
  output bht_upd_entry_s             data_o,
  input  logic                       yumi_i,
  output logic [$clog2(els_p):0]     count_o
);

  localparam int unsigned ptr_w_lp = $clog2(els_p);
  localparam int unsigned cnt_w_lp = ptr_w_lp + 1;
  localparam logic [cnt_w_lp-1:0] els_lp = cnt_w_lp'(els_p);

  bht_upd_entry_s        mem_q [els_p];
  logic [ptr_w_lp-1:0]   rd_ptr_q, wr_ptr_q;
  logic [cnt_w_lp-1:0]   count_q, count_d;
  logic                  enq, deq;

  assign ready_o = (count_q != els_lp);
  assign v_o     = (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  always_comb begin
    count_d = count_q;
    unique case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally since els_p is a power of two.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (deq) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/bp_fe_bht_upd_sched.sv
// Arbitrates a single-ported BHT between prediction reads and queued branch updates,
// forcing a drain when updates starve. Define BP_UPD_SCHED_STATS_EN to add stall/force counters.
module bp_fe_bht_upd_sched
  import bp_fe_bht_upd_sched_pkg::*;
#(
  parameter int unsigned bht_idx_width_p = 9,
  parameter int unsigned queue_els_p     = 4,
  parameter int unsigned starve_limit_p  = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       upd_v_i,
  input  logic [bht_idx_width_p-1:0] upd_idx_i,
  input  logic                       upd_correct_i,
  output logic                       upd_ready_o,
  input  logic                       r_v_i,
  input  logic [bht_idx_width_p-1:0] idx_r_i,
  output logic                       r_stall_o,
  output logic                       bht_r_v_o,
  output logic [bht_idx_width_p-1:0] bht_idx_r_o,
  output logic                       bht_w_v_o,
  output logic [bht_idx_width_p-1:0] bht_idx_w_o,
  output logic                       bht_correct_o
`ifdef BP_UPD_SCHED_STATS_EN
  ,
  output logic [31:0]                stall_cnt_o,
  output logic [31:0]                force_cnt_o
`endif
);

  localparam int unsigned cnt_w_lp = $clog2(queue_els_p) + 1;
  localparam int unsigned sc_w_lp  = $clog2(starve_limit_p + 1);
  localparam logic [sc_w_lp-1:0] limit_lp = sc_w_lp'(starve_limit_p);

  bht_upd_state_e       state_q, state_d;
  logic [sc_w_lp-1:0]   starve_q, starve_d;
  bht_upd_entry_s       enq_entry, head_entry;
  logic                 fifo_ready, fifo_v, fifo_yumi;
  logic [cnt_w_lp-1:0]  fifo_cnt;
  logic                 enq, write_denied, last_deq;

  always_comb begin
    enq_entry.idx     = bht_idx_width_max_gp'(upd_idx_i);
    enq_entry.correct = upd_correct_i;
  end

  bp_fe_bht_upd_fifo #(
    .els_p (queue_els_p)
  ) fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (upd_v_i),
    .data_i  (enq_entry),
    .ready_o (fifo_ready),
    .v_o     (fifo_v),
    .data_o  (head_entry),
    .yumi_i  (fifo_yumi),
    .count_o (fifo_cnt)
  );

  assign enq           = upd_v_i & fifo_ready;
  assign fifo_yumi     = bht_w_v_o;
  assign upd_ready_o   = reset_i | fifo_ready;
  assign bht_idx_r_o   = idx_r_i;
  assign bht_idx_w_o   = bht_idx_width_p'(head_entry.idx);
  assign bht_correct_o = head_entry.correct;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= e_normal;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    write_denied = (state_q == e_normal) & fifo_v & r_v_i;
    last_deq     = (fifo_cnt == cnt_w_lp'(1)) & fifo_yumi & ~enq;

    starve_d = starve_q;
    if (!fifo_v || fifo_yumi)                      starve_d = '0;
    else if (write_denied && starve_q != limit_lp) starve_d = starve_q + 1'b1;

    state_d = state_q;
    unique case (state_q)
      e_normal: if (write_denied && (starve_d == limit_lp || !fifo_ready)) state_d = e_force;
      e_force:  if (last_deq || !fifo_v) state_d = e_normal;
      default:  state_d = e_normal;
    endcase
  end

  // Reset overrides the registered state so the port contract holds from the first reset cycle.
  always_comb begin
    bht_r_v_o = r_v_i;
    bht_w_v_o = 1'b0;
    r_stall_o = 1'b0;
    if (!reset_i) begin
      unique case (state_q)
        e_force: begin
          bht_r_v_o = 1'b0;
          bht_w_v_o = fifo_v;
          r_stall_o = r_v_i;
        end
        default: begin
          bht_r_v_o = r_v_i;
          bht_w_v_o = ~r_v_i & fifo_v;
          r_stall_o = 1'b0;
        end
      endcase
    end
  end

`ifdef BP_UPD_SCHED_STATS_EN
  logic [31:0] stall_cnt_q, force_cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_cnt_q <= '0;
      force_cnt_q <= '0;
    end else begin
      if (r_stall_o) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (state_q == e_normal && state_d == e_force) force_cnt_q <= force_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign force_cnt_o = force_cnt_q;
`endif

endmodule

// File: tb/tb_bp_fe_bht_upd_sched.sv
// Directed and random checks of the BHT update scheduler against a queue-based model.
module tb_bp_fe_bht_upd_sched;

  localparam int W = 9;
  localparam int N = 4;
  localparam int L = 8;

  logic         clk = 1'b0;
  logic         reset_i, upd_v_i, upd_correct_i, r_v_i;
  logic [W-1:0] upd_idx_i, idx_r_i;
  logic         upd_ready_o, r_stall_o, bht_r_v_o, bht_w_v_o, bht_correct_o;
  logic [W-1:0] bht_idx_r_o, bht_idx_w_o;
`ifdef BP_UPD_SCHED_STATS_EN
  logic [31:0]  stall_cnt_o, force_cnt_o;
`endif

  always #5 clk = ~clk;

  bp_fe_bht_upd_sched #(
    .bht_idx_width_p (W),
    .queue_els_p     (N),
    .starve_limit_p  (L)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .upd_v_i       (upd_v_i),
    .upd_idx_i     (upd_idx_i),
    .upd_correct_i (upd_correct_i),
    .upd_ready_o   (upd_ready_o),
    .r_v_i         (r_v_i),
    .idx_r_i       (idx_r_i),
    .r_stall_o     (r_stall_o),
    .bht_r_v_o     (bht_r_v_o),
    .bht_idx_r_o   (bht_idx_r_o),
    .bht_w_v_o     (bht_w_v_o),
    .bht_idx_w_o   (bht_idx_w_o),
    .bht_correct_o (bht_correct_o)
`ifdef BP_UPD_SCHED_STATS_EN
    ,
    .stall_cnt_o   (stall_cnt_o),
    .force_cnt_o   (force_cnt_o)
`endif
  );

  typedef struct {
    logic [W-1:0] idx;
    logic         c;
  } ent_t;

  ent_t mq[$];
  bit   m_force;
  int   m_starve;
  int   m_stall_cnt, m_force_cnt;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic obs_stall, obs_w;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit uv, input logic [W-1:0] ui, input bit uc,
                      input bit rv, input logic [W-1:0] ri, input bit rst);
    bit e_ready, e_rv, e_w, e_stall, acc, denied;
    int was;
    upd_v_i = uv; upd_idx_i = ui; upd_correct_i = uc;
    r_v_i = rv; idx_r_i = ri; reset_i = rst;
    #1;
    was = mq.size();
    if (rst) begin
      e_ready = 1; e_rv = rv; e_w = 0; e_stall = 0;
    end else begin
      e_ready = (was < N);
      if (!m_force) begin e_rv = rv; e_w = !rv && was > 0; e_stall = 0; end
      else          begin e_rv = 0;  e_w = was > 0;        e_stall = rv; end
    end
    chk("upd_ready", 32'(upd_ready_o), 32'(e_ready));
    chk("bht_r_v",   32'(bht_r_v_o),   32'(e_rv));
    chk("bht_w_v",   32'(bht_w_v_o),   32'(e_w));
    chk("r_stall",   32'(r_stall_o),   32'(e_stall));
    if (e_rv) chk("bht_idx_r", 32'(bht_idx_r_o), 32'(ri));
    if (e_w) begin
      chk("bht_idx_w",   32'(bht_idx_w_o),   32'(mq[0].idx));
      chk("bht_correct", 32'(bht_correct_o), 32'(mq[0].c));
    end
`ifdef BP_UPD_SCHED_STATS_EN
    chk("stall_cnt", stall_cnt_o, 32'(m_stall_cnt));
    chk("force_cnt", force_cnt_o, 32'(m_force_cnt));
`endif
    obs_stall = r_stall_o;
    obs_w     = bht_w_v_o;
    @(posedge clk);
    if (rst) begin
      mq.delete(); m_force = 0; m_starve = 0; m_stall_cnt = 0; m_force_cnt = 0;
    end else begin
      acc    = uv && was < N;
      denied = !m_force && was > 0 && !e_w;
      if (e_w) void'(mq.pop_front());
      if (acc) mq.push_back('{idx: ui, c: uc});
      if (e_stall) m_stall_cnt++;
      if (was == 0 || e_w) m_starve = 0;
      else if (denied && m_starve < L) m_starve++;
      if (!m_force) begin
        if (denied && (m_starve == L || was == N)) begin m_force = 1; m_force_cnt++; end
      end else if (mq.size() == 0) m_force = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    int reads, stalls, prob;
    upd_v_i = 0; upd_idx_i = '0; upd_correct_i = 0; r_v_i = 0; idx_r_i = '0; reset_i = 1;
    @(negedge clk);
    step(0, 0, 0, 1, 9'd77, 1);
    step(0, 0, 0, 0, 0, 1);

    // In-order writes one cycle after enqueue with no reads.
    step(1, 9'd5, 1, 0, 0, 0);
    step(1, 9'd9, 0, 0, 0, 0);
    step(1, 9'd12, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);

    // Starvation drain with reads held.
    step(0, 0, 0, 0, 0, 1);
    step(1, 9'd33, 1, 1, 9'd1, 0);
    reads = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 1, 9'(i), 0);
      if (obs_stall) break;
      reads++;
    end
    chk("starve_reads", 32'(reads), 32'(L));
    chk("starve_stall_seen", 32'(obs_stall), 32'd1);
    step(0, 0, 0, 1, 9'd2, 0);
    chk("reads_resume", 32'(obs_stall), 32'd0);
`ifdef BP_UPD_SCHED_STATS_EN
    chk("stats_stall_030", stall_cnt_o, 32'd1);
    chk("stats_force_030", force_cnt_o, 32'd1);
`endif

    // Full queue forces a four-write drain.
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 9'(100 + i), i[0], 1, 9'd3, 0);
    chk("full_not_ready", 32'(upd_ready_o), 32'd0);
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1, 9'd4, 0);
      if (obs_stall) stalls++;
    end
    chk("force_stalls", 32'(stalls), 32'd4);

    // Enqueue attempt while full and dequeuing in the same cycle.
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 9'(200 + i), 1, 1, 9'd5, 0);
    step(1, 9'd250, 0, 1, 9'd5, 0);
    step(1, 9'd250, 0, 1, 9'd5, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 9'd6, 0);

    // Reset pulse mid-drain discards the queue.
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 9'(300 + i), 0, 1, 9'd7, 0);
    step(0, 0, 0, 1, 9'd7, 0);
    step(0, 0, 0, 1, 9'd7, 0);
    step(0, 0, 0, 1, 9'd7, 1);
    step(0, 0, 0, 1, 9'd8, 0);
    chk("post_reset_no_write", 32'(obs_w), 32'd0);
    step(0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      case ((i / 100) % 4)
        0: prob = 90;
        1: prob = 30;
        2: prob = 100;
        default: prob = 60;
      endcase
      step(bit'($urandom_range(0, 1)), W'($urandom), bit'($urandom_range(0, 1)),
           $urandom_range(0, 99) < prob, W'($urandom), $urandom_range(0, 199) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_fe_bht_upd_sched.md
BP_FE_BHT_UPD_SCHED -- requirements
Module: bp_fe_bht_upd_sched

Interface
REQ-001 SHALL have parameter bht_idx_width_p, default 9, BHT index width.
REQ-002 SHALL have parameter queue_els_p, default 4, update queue depth (power of 2, >=2).
REQ-003 SHALL have parameter starve_limit_p, default 8, cycles of denied write before forced drain (>=1).
REQ-004 SHALL have clk_i  input  1  sole clock, rising edge.
REQ-005 SHALL have reset_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have upd_v_i / upd_idx_i / upd_correct_i  input  1 / bht_idx_width_p / 1  resolved-branch update request.
REQ-007 SHALL have upd_ready_o  output  1  update accept; transfer when upd_v_i & upd_ready_o.
REQ-008 SHALL have r_v_i / idx_r_i  input  1 / bht_idx_width_p  prediction read request.
REQ-009 SHALL have r_stall_o  output  1  read not serviced this cycle; requester re-presents.
REQ-010 SHALL have bht_r_v_o / bht_idx_r_o  output  1 / bht_idx_width_p  read port to single-ported BHT.
REQ-011 SHALL have bht_w_v_o / bht_idx_w_o / bht_correct_o  output  1 / bht_idx_width_p / 1  write port to BHT.

Function
REQ-012 SHALL buffer accepted updates in a FIFO of queue_els_p entries {idx, correct}, in order.
REQ-013 SHALL drive upd_ready_o = !full from registered occupancy; no enqueue when full, even with same-cycle dequeue.
REQ-014 SHALL issue at most one BHT access per cycle: bht_r_v_o & bht_w_v_o never both 1.
REQ-015 SHALL implement FSM states NORMAL and FORCE.
REQ-016 NORMAL: r_v_i=1 -> bht_r_v_o=1, bht_idx_r_o=idx_r_i, r_stall_o=0, no write; r_v_i=0 and queue non-empty -> write head, dequeue.
REQ-017 SHALL keep starve counter: increments in NORMAL when queue non-empty and write denied, clears on any write or empty queue, saturates at starve_limit_p.
REQ-018 NORMAL -> FORCE on next edge when counter reaches starve_limit_p, or when queue full and write denied.
REQ-019 FORCE: write head each cycle, bht_r_v_o=0, r_stall_o=r_v_i; return to NORMAL on edge after dequeue leaving queue empty; counter cleared.
REQ-020 Update latency: accepted at edge t, earliest bht_w_v_o in cycle t+1; no bypass onto write port.
REQ-021 Occupancy SHALL track enqueue+dequeue in the same cycle as unchanged; pointers wrap modulo queue_els_p.
REQ-022 bht_idx_w_o/bht_correct_o SHALL equal head entry whenever bht_w_v_o=1; values don't-care otherwise.

Reset
REQ-023 While reset_i=1 at an edge: queue emptied, pointers/occupancy 0, counter 0, state NORMAL; pending updates discarded.
REQ-024 During and after reset: upd_ready_o=1, bht_w_v_o=0, r_stall_o=0, bht_r_v_o=r_v_i.

Configuration
REQ-025 Macro BP_UPD_SCHED_STATS_EN defined: SHALL add outputs stall_cnt_o [31:0] (cycles r_stall_o=1) and force_cnt_o [31:0] (NORMAL->FORCE entries), wrap-around, cleared by reset.
REQ-026 Macro undefined: stats ports and counters SHALL be absent; other behaviour identical.

Structure
REQ-027 Package bp_fe_bht_upd_sched_pkg SHALL hold state enum and entry struct typedef (parameterized idx via width constant).
REQ-028 FIFO SHALL be sub-module bp_fe_bht_upd_fifo (valid/ready enq, yumi deq); FSM and arbitration in top.

Verification
REQ-029 Reset then 3 updates idx 5,9,12, r_v_i=0 -> writes idx 5,9,12 in cycles 1,2,3 after each enqueue, in order.
REQ-030 r_v_i held 1, 1 update queued, starve_limit_p=8 -> 8 reads granted, then 1 cycle r_stall_o=1 with write, then reads resume.
REQ-031 r_v_i held 1, 4 updates back-to-back -> upd_ready_o=0 after 4th; FORCE drains 4 writes, r_stall_o=1 four cycles.
REQ-032 Full queue, upd_v_i=1, dequeue same cycle -> no accept that cycle; accepted next cycle; order preserved.
REQ-033 reset_i pulsed with 3 entries queued during FORCE -> no further writes, upd_ready_o=1, state NORMAL next cycle.
REQ-034 With BP_UPD_SCHED_STATS_EN, scenario REQ-030 -> stall_cnt_o=1, force_cnt_o=1.
